// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings, stream
// format limits and the length-word validity check.
package imem_loader_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [2:0] ST_LEN   = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [WORD_W-1:0] LEN_MIN = 16'd1;

  // A length is usable when it is non-zero and fits the memory without wrapping.
  function automatic logic len_ok(input logic [WORD_W-1:0] n, input int unsigned aw);
    logic [31:0] depth;
    depth = 32'd1 << aw;
    return (n >= LEN_MIN) && ({16'd0, n} <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: upstream word stream, restart request, instruction-memory write
// port and the processor reset/status it drives.
interface imem_loader_if #(parameter int ADDR_W = 8);
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              load_req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output in_valid, in_data, load_req,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error, words_loaded
  );

  modport slave (
    input  in_valid, in_data, load_req,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error, words_loaded
  );

endinterface

// File: rtl/imem_ld_csum.sv
// Running 16-bit checksum of the data words; clear takes priority over add.
module imem_ld_csum
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_add_en,
  input  logic [WORD_W-1:0] i_data,
  output logic [WORD_W-1:0] o_sum
);

  logic [WORD_W-1:0] r_sum;

  // Accumulate modulo 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= 16'd0;
    end else if (i_clr) begin
      r_sum <= 16'd0;
    end else if (i_add_en) begin
      r_sum <= r_sum + i_data;
    end else begin
      r_sum <= r_sum;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a length/data/checksum word stream, writes the data into
// instruction memory and releases the processor reset only on a good image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_done;
  logic              r_error;
  logic              r_core_rst_n;

  logic              w_accepting;
  logic              w_beat;
  logic              w_restart;
  logic              w_last;
  logic              w_len_ok;
  logic              w_csum_clr;
  logic              w_csum_add;
  logic [WORD_W-1:0] w_sum;

  assign w_accepting = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CHECK);
  assign bus.in_ready = w_accepting && !rst;
  assign w_beat      = bus.in_valid && bus.in_ready;
  assign w_restart   = bus.load_req && ((r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_last      = ((r_cnt + {{ADDR_W{1'b0}}, 1'b1}) == r_len);
  assign w_len_ok    = len_ok(bus.in_data, ADDR_W);
  assign w_csum_clr  = (r_state == ST_LEN) && w_beat && w_len_ok;
  assign w_csum_add  = (r_state == ST_DATA) && w_beat;

  imem_ld_csum u_csum (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_csum_clr),
    .i_add_en (w_csum_add),
    .i_data   (bus.in_data),
    .o_sum    (w_sum)
  );

  // Next-state decode; the sum seen in CHECK already includes the last data word.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LEN: begin
        if (w_beat) w_next = w_len_ok ? ST_DATA : ST_ERR;
        else        w_next = r_state;
      end
      ST_DATA: begin
        if (w_beat && w_last) w_next = ST_CHECK;
        else                  w_next = r_state;
      end
      ST_CHECK: begin
        if (w_beat) w_next = (bus.in_data == w_sum) ? ST_DONE : ST_ERR;
        else        w_next = r_state;
      end
      ST_DONE, ST_ERR: begin
        if (bus.load_req) w_next = ST_LEN;
        else              w_next = r_state;
      end
      default: w_next = ST_ERR;
    endcase
  end

  // State, write port and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_LEN;
      r_len        <= {(ADDR_W+1){1'b0}};
      r_cnt        <= {(ADDR_W+1){1'b0}};
      r_we         <= 1'b0;
      r_addr       <= {ADDR_W{1'b0}};
      r_wdata      <= 16'd0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_done       <= (w_next == ST_DONE);
      r_error      <= (w_next == ST_ERR);
      r_core_rst_n <= (w_next == ST_DONE);
      r_we         <= 1'b0;
      if (w_csum_clr) begin
        r_len <= bus.in_data[ADDR_W:0];
        r_cnt <= {(ADDR_W+1){1'b0}};
      end else if (w_csum_add) begin
        r_we    <= 1'b1;
        r_addr  <= r_cnt[ADDR_W-1:0];
        r_wdata <= bus.in_data;
        r_cnt   <= r_cnt + {{ADDR_W{1'b0}}, 1'b1};
      end else if (w_restart) begin
        r_cnt <= {(ADDR_W+1){1'b0}};
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign bus.imem_we      = r_we;
  assign bus.imem_addr    = r_addr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.core_rst_n   = r_core_rst_n;
  assign bus.words_loaded = r_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboarded memory writes plus
// per-scenario status checks.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  logic [ADDR_W+15:0] exp_q[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [ADDR_W+15:0] exp_w;
    if (bus.imem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== exp_w) begin
          errors++;
          $display("FAIL write got=%0h/%0h required=%0h/%0h", bus.imem_addr, bus.imem_wdata,
                   exp_w[ADDR_W+15:16], exp_w[15:0]);
        end
      end
    end
  end

  // One beat; the strobe must appear exactly in the following cycle. Optional idle gap after.
  task automatic send_word(input logic [15:0] d, input logic is_data, input int addr, input bit gap);
    logic [ADDR_W-1:0] a;
    a = addr[ADDR_W-1:0];
    if (is_data) exp_q.push_back({a, d});
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.imem_we !== is_data) begin
      errors++;
      $display("FAIL strobe_after_beat got=%b required=%b", bus.imem_we, is_data);
    end
    if (gap) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.imem_we !== 1'b0) begin
        errors++;
        $display("FAIL strobe_in_gap got=%b required=0", bus.imem_we);
      end
    end
  endtask

  task automatic pulse_load_req();
    bus.load_req = 1'b1;
    @(posedge clk); #1;
    bus.load_req = 1'b0;
    vectors++;
    if ({bus.core_rst_n, bus.done, bus.error, bus.words_loaded, bus.in_ready} !== {3'b000, 9'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart got rstn/done/err/wl/rdy=%b/%b/%b/%0d/%b required=0/0/0/0/1",
               bus.core_rst_n, bus.done, bus.error, bus.words_loaded, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if ({bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b0, 1'b0, 8'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_port rdy/we/addr/wd=%b/%b/%0h/%0h required=0/0/0/0",
               bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
    vectors++;
    if ({bus.core_rst_n, bus.done, bus.error, bus.words_loaded} !== {3'b000, 9'd0}) begin
      errors++;
      $display("FAIL reset_status rstn/done/err/wl=%b/%b/%b/%0d required=0/0/0/0",
               bus.core_rst_n, bus.done, bus.error, bus.words_loaded);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b required=1", bus.in_ready);
    end
  endtask

  task automatic test_good_stream();
    send_word(16'h0003, 1'b0, 0, 1'b0);
    send_word(16'h1111, 1'b1, 0, 1'b0);
    send_word(16'h2222, 1'b1, 1, 1'b0);
    send_word(16'h3333, 1'b1, 2, 1'b0);
    vectors++;
    if ({bus.core_rst_n, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL core_held_before_check rstn/done=%b/%b required=0/0", bus.core_rst_n, bus.done);
    end
    send_word(16'h6666, 1'b0, 0, 1'b0);
    vectors++;
    if ({bus.done, bus.core_rst_n, bus.error, bus.words_loaded, bus.in_ready} !== {3'b110, 9'd3, 1'b0}) begin
      errors++;
      $display("FAIL good_stream done/rstn/err/wl/rdy=%b/%b/%b/%0d/%b required=1/1/0/3/0",
               bus.done, bus.core_rst_n, bus.error, bus.words_loaded, bus.in_ready);
    end
  endtask

  task automatic test_bad_checksum();
    pulse_load_req();
    send_word(16'h0003, 1'b0, 0, 1'b0);
    send_word(16'h1111, 1'b1, 0, 1'b0);
    send_word(16'h2222, 1'b1, 1, 1'b0);
    send_word(16'h3333, 1'b1, 2, 1'b0);
    send_word(16'h6667, 1'b0, 0, 1'b0);
    vectors++;
    if ({bus.error, bus.core_rst_n, bus.done, bus.words_loaded} !== {3'b100, 9'd3}) begin
      errors++;
      $display("FAIL bad_checksum err/rstn/done/wl=%b/%b/%b/%0d required=1/0/0/3",
               bus.error, bus.core_rst_n, bus.done, bus.words_loaded);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.error, bus.in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL err_hold err/rdy=%b/%b required=1/0", bus.error, bus.in_ready);
    end
  endtask

  task automatic test_max_length();
    logic [15:0] sum;
    logic [15:0] d;
    sum = 16'd0;
    pulse_load_req();
    send_word(16'h0100, 1'b0, 0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      d = 16'(i * 16'h0101 + 16'h00f3);
      sum = sum + d;
      send_word(d, 1'b1, i, 1'b0);
    end
    send_word(sum, 1'b0, 0, 1'b0);
    vectors++;
    if ({bus.done, bus.core_rst_n, bus.words_loaded} !== {2'b11, 9'h100}) begin
      errors++;
      $display("FAIL max_length done/rstn/wl=%b/%b/%0d required=1/1/256", bus.done, bus.core_rst_n, bus.words_loaded);
    end
  endtask

  task automatic test_bad_length();
    logic [15:0] lens[2];
    lens[0] = 16'h0000;
    lens[1] = 16'h0101;
    for (int i = 0; i < 2; i++) begin
      pulse_load_req();
      send_word(lens[i], 1'b0, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({bus.error, bus.done, bus.core_rst_n, bus.words_loaded, bus.imem_we} !== {3'b100, 9'd0, 1'b0}) begin
        errors++;
        $display("FAIL bad_length len=%0h err/done/rstn/wl/we=%b/%b/%b/%0d/%b required=1/0/0/0/0",
                 lens[i], bus.error, bus.done, bus.core_rst_n, bus.words_loaded, bus.imem_we);
      end
    end
  endtask

  task automatic test_load_req_with_valid();
    bus.load_req = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0002;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_err got=%b required=0", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.error, bus.words_loaded, bus.in_ready, bus.imem_we} !== {1'b0, 9'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart_with_valid err/wl/rdy/we=%b/%0d/%b/%b required=0/0/1/0",
               bus.error, bus.words_loaded, bus.in_ready, bus.imem_we);
    end
    send_word(16'h0002, 1'b0, 0, 1'b0);
    send_word(16'h0001, 1'b1, 0, 1'b0);
    send_word(16'h0001, 1'b1, 1, 1'b0);
    send_word(16'h0002, 1'b0, 0, 1'b0);
    vectors++;
    if ({bus.done, bus.core_rst_n, bus.words_loaded} !== {2'b11, 9'd2}) begin
      errors++;
      $display("FAIL restart_stream done/rstn/wl=%b/%b/%0d required=1/1/2", bus.done, bus.core_rst_n, bus.words_loaded);
    end
  endtask

  task automatic test_gaps();
    pulse_load_req();
    send_word(16'h0003, 1'b0, 0, 1'b1);
    send_word(16'h1111, 1'b1, 0, 1'b1);
    bus.load_req = 1'b1;
    @(posedge clk); #1;
    bus.load_req = 1'b0;
    vectors++;
    if ({bus.words_loaded, bus.error, bus.done, bus.in_ready} !== {9'd1, 3'b001}) begin
      errors++;
      $display("FAIL load_req_ignored wl/err/done/rdy=%0d/%b/%b/%b required=1/0/0/1",
               bus.words_loaded, bus.error, bus.done, bus.in_ready);
    end
    send_word(16'h2222, 1'b1, 1, 1'b1);
    send_word(16'h3333, 1'b1, 2, 1'b1);
    send_word(16'h6666, 1'b0, 0, 1'b1);
    vectors++;
    if ({bus.done, bus.core_rst_n, bus.error, bus.words_loaded} !== {3'b110, 9'd3}) begin
      errors++;
      $display("FAIL gaps_final done/rstn/err/wl=%b/%b/%b/%0d required=1/1/0/3",
               bus.done, bus.core_rst_n, bus.error, bus.words_loaded);
    end
  endtask

  task automatic test_rst_midload();
    pulse_load_req();
    send_word(16'h0003, 1'b0, 0, 1'b0);
    send_word(16'h1111, 1'b1, 0, 1'b0);
    send_word(16'h2222, 1'b1, 1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.core_rst_n, bus.done, bus.error, bus.words_loaded}
        !== {1'b0, 1'b0, 8'd0, 16'd0, 3'b000, 9'd0}) begin
      errors++;
      $display("FAIL rst_midload rdy/we/addr/wd/rstn/done/err/wl=%b/%b/%0h/%0h/%b/%b/%b/%0d required all 0",
               bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.core_rst_n, bus.done, bus.error,
               bus.words_loaded);
    end
    rst = 1'b0;
    send_word(16'h0003, 1'b0, 0, 1'b0);
    send_word(16'h1111, 1'b1, 0, 1'b0);
    send_word(16'h2222, 1'b1, 1, 1'b0);
    send_word(16'h3333, 1'b1, 2, 1'b0);
    send_word(16'h6666, 1'b0, 0, 1'b0);
    vectors++;
    if ({bus.done, bus.core_rst_n, bus.words_loaded} !== {2'b11, 9'd3}) begin
      errors++;
      $display("FAIL after_rst_stream done/rstn/wl=%b/%b/%0d required=1/1/3", bus.done, bus.core_rst_n, bus.words_loaded);
    end
    @(posedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL writes_outstanding got=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'd0;
    bus.load_req = 1'b0;
    test_reset();
    test_good_stream();
    test_bad_checksum();
    test_max_length();
    test_bad_length();
    test_load_req_with_valid();
    test_gaps();
    test_rst_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
